// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                                |
// | Purpose  : Instruction fetch sequencer. Owns the program counter, issues   |
// |            instruction-memory reads, holds the fetched word for decode and |
// |            computes the next PC from the control unit's pc_sel/brEn/halt.  |
// | Ports    : CLK, nRST (sync, active-low)                                    |
// |            iwait, iload        <- instruction memory                       |
// |            iREN, iaddr         -> instruction memory                       |
// |            instr, instr_valid  -> control unit                             |
// |            adv                 <- datapath (retire current instruction)    |
// |            pc_sel, brEn, halt  <- control unit                             |
// |            jr_target, br_imm   <- register file / sign-extended immediate  |
// |            pc_plus4            -> JAL writeback                            |
// |            halted              -> sticky halt indicator                    |
// |            fetch_count,                                                    |
// |            stall_count         -> performance counters                     |
// | Config   : define FETCH_PERF_EN to build the two performance counters;     |
// |            otherwise both counter ports are tied to zero.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        adv,
  input  logic [1:0]  pc_sel,
  input  logic        brEn,
  input  logic        halt,
  input  logic [31:0] jr_target,
  input  logic [31:0] br_imm,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [1:0] PC_SEL_REG  = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP = 2'b10;

  // Low bits are forced clear so the PC can never leave word alignment.
  localparam logic [31:0] PC_RESET = {PC_INIT[31:2], 2'b00};

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_seq;
  logic [31:0] pc_target;
  logic        capture;
  logic        retire;

  // Bits that the PC arithmetic deliberately discards.
  logic unused_bits;
  assign unused_bits = &{1'b0, jr_target[1:0], instr_q[31:26]};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. halt outranks adv; HALTED is left only through reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (!iwait) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (halt)     state_d = S_HALTED;
        else if (adv) state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    iREN        = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH:  iREN        = 1'b1;
      S_ISSUE:  instr_valid = 1'b1;
      S_HALTED: halted      = 1'b1;
      default:  iREN        = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC / instruction datapath
  // ---------------------------------------------------------------------------
  assign capture = (state_q == S_FETCH) && !iwait;
  assign retire  = (state_q == S_ISSUE) && !halt && adv;

  assign pc_seq = pc_q + 32'd4;

  // pc_sel 11 falls into the sequential/branch arm; brEn only matters there.
  always_comb begin
    pc_target = pc_seq;
    case (pc_sel)
      PC_SEL_REG:  pc_target = {jr_target[31:2], 2'b00};
      PC_SEL_JUMP: pc_target = {pc_seq[31:28], instr_q[25:0], 2'b00};
      default: begin
        if (brEn) pc_target = pc_seq + (br_imm << 2);
        else      pc_target = pc_seq;
      end
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (retire)  pc_d    = pc_target;
    if (capture) instr_d = iload;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign iaddr    = pc_q;
  assign pc_plus4 = pc_seq;
  assign instr    = instr_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (retire)                           fetch_cnt_d = fetch_cnt_q + 32'd1;
    if ((state_q == S_FETCH) && iwait)    stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                             |
// | Purpose  : Self-checking bench for instr_fetch_unit: directed next-PC      |
// |            table, reset/sequential/stall/halt sequences and randomized     |
// |            instruction streams against a behavioural PC model.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0200;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iwait;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        adv;
  logic [1:0]  pc_sel;
  logic        brEn;
  logic        halt;
  logic [31:0] jr_target;
  logic [31:0] br_imm;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  instr_fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .iwait       (iwait),
    .iload       (iload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .adv         (adv),
    .pc_sel      (pc_sel),
    .brEn        (brEn),
    .halt        (halt),
    .jr_target   (jr_target),
    .br_imm      (br_imm),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  typedef struct {
    logic [31:0] start_pc;
    logic [31:0] word;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] jr;
    logic [31:0] imm;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t table_v[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_counters;
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, m_fetch);
    chk("stall_count", stall_count, m_stall);
`else
    chk("fetch_count", fetch_count, 32'd0);
    chk("stall_count", stall_count, 32'd0);
`endif
  endtask

  // Next PC straight from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic [1:0] sel, input logic br,
                                             input logic [31:0] jr, input logic [31:0] imm);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (sel == 2'b01)      return jr & 32'hFFFF_FFFC;
    else if (sel == 2'b10) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    else if (br)           return seq + imm * 32'd4;
    else                   return seq;
  endfunction

  task automatic do_reset;
    nRST  = 1'b0;
    iwait = $urandom_range(0, 1);
    adv   = $urandom_range(0, 1);
    halt  = $urandom_range(0, 1);
    step;
    nRST  = 1'b1;
    iwait = 1'b0;
    adv   = 1'b0;
    halt  = 1'b0;
    m_pc    = PC_INIT;
    m_fetch = 32'd0;
    m_stall = 32'd0;
    chk("reset iREN", {31'd0, iREN}, 32'd1);
    chk("reset iaddr", iaddr, PC_INIT);
    chk("reset instr", instr, 32'd0);
    chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);
    chk_counters();
  endtask

  // One full instruction: optional iwait stalls, FETCH->ISSUE, optional hold
  // cycles in ISSUE, then retire with the given control inputs.
  task automatic run_instr(input logic [31:0] word, input int waits, input int holds,
                           input logic [1:0] sel, input logic br,
                           input logic [31:0] jr, input logic [31:0] imm);
    chk("fetch iREN", {31'd0, iREN}, 32'd1);
    chk("fetch iaddr", iaddr, m_pc);
    for (int i = 0; i < waits; i++) begin
      iwait = 1'b1;
      iload = $urandom;
      adv   = $urandom_range(0, 1);
      halt  = $urandom_range(0, 1);
      step;
      m_stall = m_stall + 32'd1;
      chk("stall instr_valid", {31'd0, instr_valid}, 32'd0);
      chk("stall iaddr", iaddr, m_pc);
    end
    iwait = 1'b0;
    iload = word;
    adv   = $urandom_range(0, 1);
    halt  = $urandom_range(0, 1);
    step;
    halt = 1'b0;
    adv  = 1'b0;
    iload = $urandom;
    chk("issue instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("issue iREN", {31'd0, iREN}, 32'd0);
    chk("issue instr", instr, word);
    chk("issue pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < holds; i++) begin
      iwait = $urandom_range(0, 1);
      iload = $urandom;
      step;
      chk("hold instr", instr, word);
      chk("hold instr_valid", {31'd0, instr_valid}, 32'd1);
    end
    iwait     = $urandom_range(0, 1);
    pc_sel    = sel;
    brEn      = br;
    jr_target = jr;
    br_imm    = imm;
    adv       = 1'b1;
    step;
    adv     = 1'b0;
    iwait   = 1'b0;
    m_pc    = model_next(m_pc, word, sel, br, jr, imm);
    m_fetch = m_fetch + 32'd1;
    chk("retire iaddr", iaddr, m_pc);
    chk("retire iREN", {31'd0, iREN}, 32'd1);
    chk_counters();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    nRST = 1'b1; iwait = 1'b0; iload = 32'd0; adv = 1'b0; pc_sel = 2'b00;
    brEn = 1'b0; halt = 1'b0; jr_target = 32'd0; br_imm = 32'd0;

    table_v[0] = '{32'h0000_0040, 32'h0,         2'b00, 1'b1, 32'h0,       32'hFFFF_FFFE, 32'h0000_003C};
    table_v[1] = '{32'h0000_0040, 32'h0,         2'b00, 1'b0, 32'h0,       32'hFFFF_FFFE, 32'h0000_0044};
    table_v[2] = '{32'h0000_0040, 32'h0,         2'b01, 1'b0, 32'h0000_1003, 32'h0,       32'h0000_1000};
    table_v[3] = '{32'h8000_0000, 32'h0800_0100, 2'b10, 1'b0, 32'h0,       32'h0,         32'h8000_0400};
    table_v[4] = '{32'h0000_0040, 32'h0,         2'b11, 1'b1, 32'h0,       32'h0000_0001, 32'h0000_0048};
    table_v[5] = '{32'h0000_0040, 32'h0,         2'b01, 1'b1, 32'h0000_2002, 32'h0000_0010, 32'h0000_2000};
    table_v[6] = '{32'hFFFF_FFFC, 32'h0,         2'b00, 1'b0, 32'h0,       32'h0,         32'h0000_0000};
    table_v[7] = '{32'hEFFF_FFFC, 32'hFFFF_FFFF, 2'b10, 1'b1, 32'h0,       32'h0000_0004, 32'hFFFF_FFFC};
    table_v[8] = '{32'h0000_0100, 32'h0,         2'b00, 1'b1, 32'h0,       32'h0000_0010, 32'h0000_0144};
    table_v[9] = '{32'h0000_0100, 32'h0,         2'b10, 1'b1, 32'h0,       32'h0000_0010, 32'h0000_0000};

    // Sequential stream from reset: fetch/issue alternate, PC steps by 4.
    do_reset();
    adv = 1'b1; pc_sel = 2'b00; brEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = $urandom;
      chk("seq iaddr", iaddr, PC_INIT + 32'(4 * k));
      chk("seq iREN fetch", {31'd0, iREN}, 32'd1);
      iload = w;
      step;
      chk("seq iREN issue", {31'd0, iREN}, 32'd0);
      chk("seq instr", instr, w);
      step;
    end
    adv = 1'b0;
    chk("seq end iaddr", iaddr, PC_INIT + 32'd16);

    // Three stall cycles immediately after reset.
    do_reset();
    run_instr(32'h1234_5678, 3, 0, 2'b00, 1'b0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("stall_count three", stall_count, 32'd3);
`else
    chk("stall_count tied", stall_count, 32'd0);
`endif

    // Directed next-PC table: JR to the start PC, then the instruction under test.
    for (int t = 0; t < 10; t++) begin
      run_instr(32'h0, 0, 0, 2'b01, 1'b0, table_v[t].start_pc, 32'h0);
      chk("table start pc", iaddr, table_v[t].start_pc);
      run_instr(table_v[t].word, $urandom_range(0, 1), $urandom_range(0, 1),
                table_v[t].sel, table_v[t].br, table_v[t].jr, table_v[t].imm);
      chk("table next pc", iaddr, table_v[t].exp_pc);
    end

    // Randomized instruction stream against the model.
    do_reset();
    for (int r = 0; r < 60; r++) begin
      logic [31:0] imm;
      imm = {{16{$urandom_range(0, 1) == 1}}, 16'($urandom)};
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, imm);
    end

    // halt and adv together: halt wins, PC frozen, sticky until reset.
    run_instr(32'h0, 0, 0, 2'b01, 1'b0, 32'h0000_0880, 32'h0);
    iload = 32'hDEAD_BEEF;
    step;
    chk("pre-halt instr_valid", {31'd0, instr_valid}, 32'd1);
    halt = 1'b1; adv = 1'b1; pc_sel = 2'b10; brEn = 1'b1;
    step;
    chk("halt halted", {31'd0, halted}, 32'd1);
    chk("halt iREN", {31'd0, iREN}, 32'd0);
    chk("halt instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt iaddr", iaddr, 32'h0000_0880);
    chk_counters();
    halt = 1'b0; adv = 1'b1; iwait = 1'b0;
    step; step; step;
    chk("halt sticky", {31'd0, halted}, 32'd1);
    chk("halt sticky iaddr", iaddr, 32'h0000_0880);
    adv = 1'b0;
    do_reset();
    run_instr($urandom, 1, 1, 2'b00, 1'b1, 32'h0, 32'h0000_0003);

    // Reset in the middle of a stalled fetch.
    run_instr(32'h0, 0, 0, 2'b01, 1'b0, 32'h0000_4000, 32'h0);
    iwait = 1'b1;
    step;
    step;
    do_reset();
    chk("midfetch iaddr", iaddr, PC_INIT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
